spike_aer_scheduler: RTL and testbench
======================================

# spike_aer_scheduler

Serializes a neuron-layer spike vector into a stream of address events (AER), one neuron index per cycle, highest index first. Sits between the neuron array's per-timestep spike output and the event bus / synapse lookup. It owns the 16-to-4 highest-index-wins priority encoding plus the sequencing around it: capture, iteration, clearing, and frame completion. Both sides use valid/ready handshakes so that a stalled consumer back-pressures the neuron array.

## Interface
- N, 16, number of neurons (spike-vector width); fixed at 16 for this revision
- AW, 4, address width, equal to log2(N)
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronized externally
- spk_valid  in  1  spike vector on spk_vec is offered
- spk_ready  out  1  block accepts a vector this cycle
- spk_vec  in  N  one bit per neuron; 1 means the neuron fired this timestep
- aer_valid  out  1  aer_addr holds a valid event
- aer_ready  in  1  consumer takes the event this cycle
- aer_addr  out  AW  index of the firing neuron
- aer_last  out  1  this event is the final one of the current frame
- frame_done  out  1  single-cycle pulse when a frame is fully drained, including empty frames
- frame_cnt  out  16  count of completed frames; wraps from 0xFFFF to 0

## Operation
- Internal state: a 2-state FSM (IDLE, DRAIN) and an N-bit pending register `pend`.
- IDLE:
  - spk_ready=1 and aer_valid=0.
  - On spk_valid&spk_ready with spk_vec!=0: pend<=spk_vec, then go to DRAIN.
  - On spk_valid&spk_ready with spk_vec==0: stay in IDLE. frame_done pulses the next cycle and frame_cnt increments.
- DRAIN:
  - spk_ready=0 and aer_valid=1.
  - aer_addr is the index of the highest set bit of pend.
  - aer_last=1 when pend has exactly one bit set.
  - On aer_valid&aer_ready: clear bit aer_addr in pend. If aer_last is set, go to IDLE, pulse frame_done, and increment frame_cnt.
- Encoding rule: the highest-numbered set bit wins, so bit 15 is served first and bit 0 last.
- While aer_valid=1 and aer_ready=0: aer_addr, aer_last and pend hold stable. The event must not be dropped or reordered.
- aer_addr=0 and aer_last=0 whenever aer_valid=0.
- spk_vec is sampled only on the accepting edge. Changes at any other time are ignored.
- aer_ready has no effect when aer_valid=0.
- spk_valid while spk_ready=0 has no effect. The source must hold the vector until it is accepted.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - State is IDLE and pend=0.
  - aer_valid=0, aer_addr=0, aer_last=0, frame_done=0, frame_cnt=0.
  - spk_ready=1, since it is decoded from IDLE.
- Reset asserted mid-DRAIN discards the remaining events immediately. No frame_done is produced and frame_cnt is cleared.
- Latency: a vector accepted at edge k gives aer_valid=1 from cycle k+1, i.e. one cycle after acceptance.
- Throughput: one event per cycle while aer_ready=1.
- A frame with P set bits and aer_ready held at 1:
  - Events are presented in cycles k+1..k+P. The last event is taken at edge k+P, after which the FSM is back in IDLE.
  - frame_done=1 in cycle k+P+1 and spk_ready=1 in cycle k+P+1.
  - The next vector can be accepted at edge k+P+1, which gives one bubble cycle between frames.
- An empty vector accepted at edge k gives frame_done=1 in cycle k+1 and no aer_valid.
- frame_done lasts exactly one cycle. frame_cnt updates on the same edge that raises frame_done.
- aer_valid, aer_addr and aer_last are combinational from registered state only. There is no path from aer_ready to them.
- spk_ready is a decode of registered state only. There is no path from spk_valid to it.

## Test plan
- Reset then idle:
  - Stimulus: rst_n low for 3 cycles, then release.
  - Required: spk_ready=1, aer_valid=0, frame_cnt=0 throughout; frame_done never pulses.
- Full-rate drain:
  - Stimulus: spk_vec=0x8421 with aer_ready=1.
  - Required: aer_addr sequence 15, 10, 5, 0 on consecutive cycles, with aer_last only on addr 0.
  - Required: frame_done one cycle later; frame_cnt=1.
- Back-pressure:
  - Stimulus: spk_vec=0x0003 with aer_ready low for 4 cycles, then high.
  - Required: aer_addr=1 held stable for all 4 stall cycles, then addr 0 with aer_last=1; exactly 2 events total.
- Empty frame and back-to-back vectors:
  - Stimulus: vector 0x0000, then 0xFFFF offered continuously.
  - Required: frame_done in the cycle after the empty vector with no events.
  - Required: the 16 events run 15 down to 0; spk_ready stays low until the cycle after the last event.
- Reset mid-frame:
  - Stimulus: spk_vec=0xF000; after 2 events are taken, pulse rst_n low.
  - Required: aer_valid drops immediately; no frame_done; frame_cnt=0; spk_ready=1 after release.
- Counter wrap:
  - Stimulus: force frame_cnt to 0xFFFF, then complete one frame.
  - Required: frame_cnt=0x0000 with frame_done=1.

Source files
------------

// File: rtl/spike_aer_scheduler.sv
// spike_aer_scheduler
//   Turns one timestep's spike vector into a stream of address events,
//   one neuron index per cycle, highest index first. Empty vectors still
//   count as frames and produce a frame_done pulse.
//
// Ports
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   spk_valid    : source offers spk_vec
//   spk_ready    : scheduler is idle and will accept a vector
//   spk_vec      : one bit per neuron, 1 = fired
//   aer_valid    : aer_addr/aer_last carry an event
//   aer_ready    : consumer takes the current event
//   aer_addr     : index of the firing neuron (0 when aer_valid=0)
//   aer_last     : current event is the final one of the frame
//   frame_done   : one-cycle pulse after a frame is fully drained
//   frame_cnt    : completed-frame counter, wraps at 16 bits
module spike_aer_scheduler #(
  parameter int unsigned N  = 16,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          spk_valid,
  output logic          spk_ready,
  input  logic [N-1:0]  spk_vec,
  output logic          aer_valid,
  input  logic          aer_ready,
  output logic [AW-1:0] aer_addr,
  output logic          aer_last,
  output logic          frame_done,
  output logic [15:0]   frame_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    pend_q, pend_d;
  logic            done_d;
  logic            frame_done_q;
  logic [15:0]     frame_cnt_q;

  logic [AW-1:0]   top_idx;
  logic [N-1:0]    top_mask;
  logic            single;

  // Highest-index-wins priority encoder: later (higher) hits override.
  always_comb begin
    top_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pend_q[i]) begin
        top_idx = AW'(i);
      end
    end
  end

  always_comb begin
    top_mask = N'(1) << top_idx;
    // Exactly one bit set: non-zero and clearing the lowest bit leaves zero.
    single   = (pend_q != '0) && ((pend_q & (pend_q - N'(1))) == '0);
  end

  // Handshake outputs depend on registered state only.
  always_comb begin
    spk_ready  = (state_q == IDLE);
    aer_valid  = (state_q == DRAIN);
    aer_addr   = aer_valid ? top_idx : '0;
    aer_last   = aer_valid & single;
    frame_done = frame_done_q;
    frame_cnt  = frame_cnt_q;
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (spk_valid) begin
          if (spk_vec != '0) begin
            pend_d  = spk_vec;
            state_d = DRAIN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (aer_ready) begin
          pend_d = pend_q & ~top_mask;
          if (single) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      pend_q       <= pend_d;
      frame_done_q <= done_d;
      if (done_d) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_spike_aer_scheduler.sv
module tb_spike_aer_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spk_valid = 1'b0;
  logic        spk_ready;
  logic [15:0] spk_vec = '0;
  logic        aer_valid;
  logic        aer_ready = 1'b0;
  logic [3:0]  aer_addr;
  logic        aer_last;
  logic        frame_done;
  logic [15:0] frame_cnt;

  spike_aer_scheduler #(.N(16), .AW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spk_valid  (spk_valid),
    .spk_ready  (spk_ready),
    .spk_vec    (spk_vec),
    .aer_valid  (aer_valid),
    .aer_ready  (aer_ready),
    .aer_addr   (aer_addr),
    .aer_last   (aer_last),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is the list of set-bit indices, descending.
  int          mq[$];
  logic        m_done = 1'b0;
  logic [15:0] m_cnt = '0;
  logic        cnt_load = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    logic dn;
    if (!rst_n) begin
      mq.delete();
      m_done = 1'b0;
      m_cnt  = '0;
    end else begin
      dn = 1'b0;
      if (cnt_load) m_cnt = 16'hFFFF;
      if (mq.size() == 0) begin
        if (spk_valid) begin
          if (spk_vec == 16'h0) dn = 1'b1;
          else for (int i = 15; i >= 0; i--) if (spk_vec[i]) mq.push_back(i);
        end
      end else if (aer_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) dn = 1'b1;
      end
      m_done = dn;
      if (dn) m_cnt = m_cnt + 16'd1;
    end
  end

  always @(negedge clk) begin : compare
    int          ea;
    logic [15:0] ec;
    ea = (mq.size() != 0) ? mq[0] : 0;
    ec = cnt_load ? 16'hFFFF : m_cnt;
    chk("spk_ready",  32'(spk_ready),  32'(mq.size() == 0));
    chk("aer_valid",  32'(aer_valid),  32'(mq.size() != 0));
    chk("aer_addr",   32'(aer_addr),   32'(ea));
    chk("aer_last",   32'(aer_last),   32'(mq.size() == 1));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("frame_cnt",  32'(frame_cnt),  32'(ec));
  end

  // Event log for the literal expectations of the directed tests.
  int seen_addr[$];
  int seen_last[$];
  int seen_cyc[$];
  int cyc = 0;
  int done_cnt = 0;
  int stall1 = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst_n && aer_valid && aer_ready) begin
      seen_addr.push_back(int'(aer_addr));
      seen_last.push_back(int'(aer_last));
      seen_cyc.push_back(cyc);
    end
    if (rst_n && aer_valid && !aer_ready && aer_addr == 4'd1) stall1++;
  end

  always @(negedge clk) if (frame_done) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input string nm);
    int n;
    n = 0;
    while (done_cnt < target && n < 200) begin
      step();
      n++;
    end
    chk(nm, 32'(done_cnt >= target), 32'd1);
  endtask

  initial begin
    int b, d, s0, n, mode;
    int e4[4];
    int ea2[2];
    e4 = '{15, 10, 5, 0};
    ea2 = '{1, 0};

    // Reset then idle
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_no_done", 32'(done_cnt), 32'd0);
    chk("idle_cnt", 32'(frame_cnt), 32'd0);

    // Full-rate drain of 0x8421
    b = seen_addr.size(); d = done_cnt;
    aer_ready = 1'b1; spk_valid = 1'b1; spk_vec = 16'h8421;
    step();
    spk_valid = 1'b0;
    wait_done(d + 1, "drain_timeout");
    chk("drain_events", 32'(seen_addr.size() - b), 32'd4);
    if (seen_addr.size() - b == 4) begin
      for (int j = 0; j < 4; j++) begin
        chk("drain_addr", 32'(seen_addr[b+j]), 32'(e4[j]));
        chk("drain_last", 32'(seen_last[b+j]), 32'(j == 3));
      end
      chk("drain_rate", 32'(seen_cyc[b+3] - seen_cyc[b]), 32'd3);
    end
    chk("drain_cnt", 32'(frame_cnt), 32'd1);

    // Back-pressure with 0x0003
    b = seen_addr.size(); d = done_cnt; s0 = stall1;
    aer_ready = 1'b0; spk_valid = 1'b1; spk_vec = 16'h0003;
    step();
    spk_valid = 1'b0;
    repeat (4) step();
    aer_ready = 1'b1;
    wait_done(d + 1, "bp_timeout");
    chk("bp_stall_cycles", 32'(stall1 - s0), 32'd4);
    chk("bp_events", 32'(seen_addr.size() - b), 32'd2);
    if (seen_addr.size() - b == 2) begin
      for (int j = 0; j < 2; j++) begin
        chk("bp_addr", 32'(seen_addr[b+j]), 32'(ea2[j]));
        chk("bp_last", 32'(seen_last[b+j]), 32'(j == 1));
      end
    end
    chk("bp_cnt", 32'(frame_cnt), 32'd2);

    // Empty frame then 0xFFFF back to back
    b = seen_addr.size(); d = done_cnt;
    spk_valid = 1'b1; spk_vec = 16'h0000;
    step();
    spk_vec = 16'hFFFF;
    chk("empty_done", 32'(frame_done), 32'd1);
    step();
    spk_valid = 1'b0;
    chk("full_busy", 32'(spk_ready), 32'd0);
    wait_done(d + 2, "full_timeout");
    chk("full_events", 32'(seen_addr.size() - b), 32'd16);
    if (seen_addr.size() - b == 16) begin
      for (int j = 0; j < 16; j++) begin
        chk("full_addr", 32'(seen_addr[b+j]), 32'(15 - j));
        chk("full_last", 32'(seen_last[b+j]), 32'(j == 15));
      end
    end
    chk("full_cnt", 32'(frame_cnt), 32'd4);

    // Reset mid-frame with 0xF000
    b = seen_addr.size(); d = done_cnt;
    spk_valid = 1'b1; spk_vec = 16'hF000;
    step();
    spk_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("rst_valid_drop", 32'(aer_valid), 32'd0);
    chk("rst_ready", 32'(spk_ready), 32'd1);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step(); step();
    chk("rst_no_done", 32'(done_cnt - d), 32'd0);
    chk("rst_events", 32'(seen_addr.size() - b), 32'd2);
    chk("rst_ready_after", 32'(spk_ready), 32'd1);

    // Counter wrap
    force dut.frame_cnt_q = 16'hFFFF;
    cnt_load = 1'b1;
    step();
    release dut.frame_cnt_q;
    cnt_load = 1'b0;
    spk_valid = 1'b1; spk_vec = 16'h0001;
    step();
    spk_valid = 1'b0;
    n = 0;
    while (!frame_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_done", 32'(frame_done), 32'd1);
    chk("wrap_cnt", 32'(frame_cnt), 32'd0);
    step();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      spk_valid = ($urandom_range(0, 1) == 1);
      mode = int'($urandom_range(0, 3));
      if (mode == 0)      spk_vec = 16'h0000;
      else if (mode == 1) spk_vec = 16'h0001 << $urandom_range(0, 15);
      else                spk_vec = 16'($urandom);
      aer_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    spk_valid = 1'b0;
    aer_ready = 1'b1;
    repeat (40) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
